// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, 1-entry skid buffer and redirect handling.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
//
// state | meaning
// IDLE  | first cycle after reset, no request issued
// FETCH | request outstanding at pc, word accepted when imem_rvalid
// DRAIN | redirected while a request was owed; wait for and discard the response
// BUF   | accepted word parked in skid buffer while decode stalls
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_BUF} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] pc_plus4;
    logic        loaded;
    logic        word_accepted;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        loaded        = 1'b0;
        word_accepted = 1'b0;

        if (redirect_valid) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            skid_instr_d = NOP_INSTR;
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: begin
                    // An owed response must still be absorbed at the old address.
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                S_BUF:   state_d = S_FETCH;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_rvalid) begin
                        pc_d          = pc_plus4;
                        word_accepted = 1'b1;
                        if (!valid_q || !id_stall) begin
                            loaded   = 1'b1;
                            valid_d  = 1'b1;
                            instr_d  = imem_rdata;
                            id_pc_d  = pc_q;
                            id_pc4_d = pc_plus4;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_q;
                            state_d      = S_BUF;
                        end
                    end
                end
                S_BUF: begin
                    if (!id_stall) begin
                        loaded   = 1'b1;
                        valid_d  = 1'b1;
                        instr_d  = skid_instr_q;
                        id_pc_d  = skid_pc_q;
                        id_pc4_d = skid_pc_q + 32'd4;
                        state_d  = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
            if (!loaded && !id_stall) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            id_pc_q      <= 32'h0;
            id_pc4_q     <= 32'h0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc4   = id_pc4_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (word_accepted) perf_fetch_d = perf_fetch_q + 32'd1;
        if (!valid_q && !id_stall) perf_bubble_d = perf_bubble_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`else
    logic unused_accept;
    assign unused_accept = word_accepted;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: random-latency memory, stall/redirect stimulus and a program-order
// scoreboard of the instructions decode actually consumes.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model and consumed-instruction scoreboard.
    bit          busy = 0;
    int          lat = 0;
    int          min_lat = 0;
    int          max_lat = 0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    bit          flush_chk = 0;
    int          exp_bubble = 0;

    // Called at a negedge: respond to the visible request, score, then advance one clock.
    task automatic step();
        logic        s_req, s_valid;
        logic [31:0] s_addr, s_instr, s_pc, s_pc4;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = if_id_valid;
        s_instr = if_id_instr;
        s_pc    = if_id_pc;
        s_pc4   = if_id_pc4;
        if (flush_chk) check("flush_valid", {31'h0, s_valid}, 32'h0);
        flush_chk = 0;
        if (s_req) begin
            if (!busy) begin
                busy     = 1;
                lat      = $urandom_range(max_lat, min_lat);
                req_addr = s_addr;
            end else begin
                check("addr_stable", s_addr, req_addr);
            end
        end
        imem_rvalid = s_req && busy && (lat == 0);
        imem_rdata  = imem_rvalid ? mem_word(s_addr) : $urandom();
        if (!s_valid) check("nop_instr", s_instr, NOP);
        if (redirect_valid) begin
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
            flush_chk = 1;
        end else if (s_valid && !id_stall) begin
            check("seq_pc", s_pc, exp_pc);
            check("seq_instr", s_instr, mem_word(exp_pc));
            check("seq_pc4", s_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        if (!s_valid && !id_stall) exp_bubble++;
        @(posedge clk);
        if (busy) begin
            if (imem_rvalid) busy = 0;
            else lat--;
        end
        @(negedge clk);
    endtask

    initial begin
        int vcount;
        int n;
        repeat (3) @(negedge clk);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // Zero-wait memory: first valid on the 2nd clock after release.
        rst_n = 1'b1;
        step();
        check("t1_req_up", {31'h0, imem_req}, 32'h1);
        check("t1_valid_c1", {31'h0, if_id_valid}, 32'h0);
        step();
        check("t1_valid_c2", {31'h0, if_id_valid}, 32'h1);
        check("t1_pc0", if_id_pc, 32'h0);
        step();
        check("t1_pc4", if_id_pc, 32'h4);
        step();
        check("t1_pc8", if_id_pc, 32'h8);

        // Decode stall for 4 cycles: next word parks in the skid buffer.
        id_stall = 1'b1;
        repeat (4) begin
            step();
            check("t3_req_off", {31'h0, imem_req}, 32'h0);
            check("t3_hold_pc", if_id_pc, 32'h8);
        end
        id_stall = 1'b0;
        step();
        check("t3_skid_pc", if_id_pc, 32'hC);
        check("t3_skid_v", {31'h0, if_id_valid}, 32'h1);
        step();
        check("t3_next_pc", if_id_pc, 32'h10);

        // Three-cycle memory: one valid instruction every third cycle.
        min_lat = 2;
        max_lat = 2;
        vcount  = 0;
        repeat (9) begin
            step();
            if (if_id_valid) vcount++;
        end
        check("t2_valid_cnt", vcount, 3);

        // Redirect to 0x103 while the 0x20 fetch is pending.
        n = 0;
        while (!(imem_req && imem_addr == 32'h20 && !busy) && n < 20) begin
            step();
            n++;
        end
        check("t4_reach_20", imem_addr, 32'h20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check("t4_drain_req", {31'h0, imem_req}, 32'h1);
        check("t4_drain_addr", imem_addr, 32'h20);
        n = 0;
        while (imem_addr == 32'h20 && n < 10) begin
            step();
            n++;
        end
        check("t4_new_addr", imem_addr, 32'h100);

        // Redirect and stall together: flush wins.
        min_lat        = 0;
        max_lat        = 1;
        id_stall       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        n = 0;
        while (!if_id_valid && n < 20) begin
            step();
            n++;
        end
        check("t5_target_pc", if_id_pc, 32'h40);

        // PC wrap-around.
        min_lat        = 0;
        max_lat        = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n = 0;
        while (!if_id_valid && n < 20) begin
            step();
            n++;
        end
        check("t6_pc", if_id_pc, 32'hFFFF_FFFC);
        check("t6_pc4", if_id_pc4, 32'h0);
        step();
        check("t6_wrap_pc", if_id_pc, 32'h0);

        // Randomized mix of latency, stalls and redirects.
        min_lat = 0;
        max_lat = 3;
        repeat (3000) begin
            id_stall       = ($urandom_range(9, 0) < 3);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = $urandom();
            step();
        end
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        repeat (10) step();

`ifdef IF_PERF_CNT_EN
        check("perf_bubble", perf_bubble_cnt, exp_bubble);
`endif

        // Asynchronous reset in the middle of an outstanding request.
        min_lat = 3;
        max_lat = 3;
        n = 0;
        while (!(imem_req && busy) && n < 20) begin
            step();
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("mid_rst_instr", if_id_instr, NOP);
        check("mid_rst_pc", if_id_pc, 32'h0);
        check("mid_rst_addr", imem_addr, 32'h0);
        busy        = 0;
        imem_rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
